// File: rtl/motion_frame_sequencer.sv
// Frame sequencer for the motion-detect datapath: pops the current, hold and base
// pixel FIFOs in lockstep and presents one registered, position-tagged pixel triple per handshake.
module motion_frame_sequencer #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 576,
   parameter int PIX_W  = 24,
   parameter int FCNT_W = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic                       cfg_continuous,
   input  logic                       in_empty,
   input  logic [PIX_W-1:0]           in_dout,
   output logic                       in_rd_en,
   input  logic                       hold_empty,
   input  logic [PIX_W-1:0]           hold_dout,
   output logic                       hold_rd_en,
   input  logic                       base_empty,
   input  logic [PIX_W-1:0]           base_dout,
   output logic                       base_rd_en,
   output logic                       px_valid,
   input  logic                       px_ready,
   output logic [PIX_W-1:0]           px_in,
   output logic [PIX_W-1:0]           px_hold,
   output logic [PIX_W-1:0]           px_base,
   output logic [$clog2(WIDTH)-1:0]   px_x,
   output logic [$clog2(HEIGHT)-1:0]  px_y,
   output logic                       px_sof,
   output logic                       px_eol,
   output logic                       px_eof,
   output logic                       busy,
   output logic                       done,
   output logic [FCNT_W-1:0]          frame_count
);

   localparam int X_W = $clog2(WIDTH);
   localparam int Y_W = $clog2(HEIGHT);
   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [X_W-1:0]  x;
   logic [Y_W-1:0]  y;
   logic            heads_ready;
   logic            accept;
   logic            fire;
   logic            last_px;

   // A pop needs all three heads present and room in the output register.
   assign heads_ready = ~in_empty & ~hold_empty & ~base_empty;
   assign accept      = px_valid & px_ready;
   assign fire        = (state == RUN) & ~abort & heads_ready & (~px_valid | px_ready);
   assign last_px     = (x == X_LAST) & (y == Y_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_rd_en   = fire;
      hold_rd_en = fire;
      base_rd_en = fire;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) state_next = RUN;
         end
         RUN: begin
            if (abort)                state_next = IDLE;
            else if (fire && last_px) state_next = FLUSH;
         end
         FLUSH: begin
            if (abort)       state_next = IDLE;
            else if (accept) state_next = DONE;
         end
         DONE: begin
            done = ~abort;
            if (abort)               state_next = IDLE;
            else if (cfg_continuous) state_next = RUN;
            else                     state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output register and position counters; flags use the pre-increment position.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         px_valid <= 1'b0;
         px_in    <= '0;
         px_hold  <= '0;
         px_base  <= '0;
         px_x     <= '0;
         px_y     <= '0;
         px_sof   <= 1'b0;
         px_eol   <= 1'b0;
         px_eof   <= 1'b0;
         x        <= '0;
         y        <= '0;
      end else if (abort && state != IDLE) begin
         px_valid <= 1'b0;
         x        <= '0;
         y        <= '0;
      end else if (fire) begin
         px_valid <= 1'b1;
         px_in    <= in_dout;
         px_hold  <= hold_dout;
         px_base  <= base_dout;
         px_x     <= x;
         px_y     <= y;
         px_sof   <= (x == '0) && (y == '0);
         px_eol   <= (x == X_LAST);
         px_eof   <= last_px;
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
         end else begin
            x <= x + X_W'(1);
         end
      end else if (accept) begin
         px_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                       frame_count <= '0;
      else if (state == DONE && !abort) frame_count <= frame_count + FCNT_W'(1);
   end

endmodule

// File: tb/tb_motion_frame_sequencer.sv
// Directed bench for motion_frame_sequencer on a 4x2 frame with behavioural FWFT FIFOs.
module tb_motion_frame_sequencer;

   localparam int WIDTH  = 4;
   localparam int HEIGHT = 2;
   localparam int PIX_W  = 24;
   localparam int FCNT_W = 2;
   localparam int FRAME  = WIDTH * HEIGHT;

   typedef logic [3*PIX_W+4:0] beat_t;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              cfg_continuous = 1'b0;
   logic              in_empty, hold_empty, base_empty;
   logic              in_rd_en, hold_rd_en, base_rd_en;
   logic [PIX_W-1:0]  in_dout, hold_dout, base_dout;
   logic              px_valid;
   logic              px_ready = 1'b0;
   logic [PIX_W-1:0]  px_in, px_hold, px_base;
   logic [1:0]        px_x;
   logic [0:0]        px_y;
   logic              px_sof, px_eol, px_eof, busy, done;
   logic [FCNT_W-1:0] frame_count;

   logic [PIX_W-1:0]  mem_in   [0:63];
   logic [PIX_W-1:0]  mem_hold [0:63];
   logic [PIX_W-1:0]  mem_base [0:63];
   int                wp = 0;
   int                rp_in = 0;
   int                rp_hold = 0;
   int                rp_base = 0;
   logic              fifo_clr = 1'b1;
   logic              base_gap = 1'b0;
   int                vectors = 0;
   int                errors = 0;
   beat_t             obs;

   always #5 clock = ~clock;

   assign in_empty   = (rp_in >= wp);
   assign hold_empty = (rp_hold >= wp);
   assign base_empty = (rp_base >= wp) || base_gap;
   assign in_dout    = mem_in[rp_in[5:0]];
   assign hold_dout  = mem_hold[rp_hold[5:0]];
   assign base_dout  = mem_base[rp_base[5:0]];
   assign obs        = {px_in, px_hold, px_base, px_x, px_y, px_sof, px_eol, px_eof};

   always @(posedge clock) begin
      if (fifo_clr) begin
         rp_in   <= 0;
         rp_hold <= 0;
         rp_base <= 0;
      end else begin
         if (in_rd_en)   rp_in   <= rp_in + 1;
         if (hold_rd_en) rp_hold <= rp_hold + 1;
         if (base_rd_en) rp_base <= rp_base + 1;
      end
   end

   motion_frame_sequencer #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .FCNT_W(FCNT_W)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort),
      .cfg_continuous(cfg_continuous),
      .in_empty(in_empty), .in_dout(in_dout), .in_rd_en(in_rd_en),
      .hold_empty(hold_empty), .hold_dout(hold_dout), .hold_rd_en(hold_rd_en),
      .base_empty(base_empty), .base_dout(base_dout), .base_rd_en(base_rd_en),
      .px_valid(px_valid), .px_ready(px_ready),
      .px_in(px_in), .px_hold(px_hold), .px_base(px_base),
      .px_x(px_x), .px_y(px_y), .px_sof(px_sof), .px_eol(px_eol), .px_eof(px_eof),
      .busy(busy), .done(done), .frame_count(frame_count)
   );

   // Expected triple for FIFO entry idx presented as the k-th pixel of a frame.
   function automatic beat_t exp_beat(input int idx, input int k);
      logic [1:0] ex;
      logic [0:0] ey;
      int         kk;
      kk = k % FRAME;
      ex = 2'(kk % WIDTH);
      ey = 1'(kk / WIDTH);
      return {24'h110000 + 24'(idx), 24'h220000 + 24'(idx), 24'h330000 + 24'(idx),
              ex, ey, (kk == 0), (kk % WIDTH == WIDTH - 1), (kk == FRAME - 1)};
   endfunction

   // Inputs change just after the falling edge; outputs are observed 1ns later.
   task automatic tick(input logic rdy, input logic st, input logic ab, input logic gap);
      @(negedge clock);
      px_ready = rdy;
      start    = st;
      abort    = ab;
      base_gap = gap;
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; fifo_clr = 1'b1; start = 1'b0; abort = 1'b0;
      cfg_continuous = 1'b0; px_ready = 1'b0; base_gap = 1'b0; wp = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1; fifo_clr = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; fifo_clr = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b1; wp = 8;
      repeat (2) @(negedge clock);
      #1;
      vectors++;
      if ({px_valid, busy, done, frame_count, in_rd_en, hold_rd_en, base_rd_en, obs} !== '0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b busy=%b done=%b fc=%0d rd=%b%b%b px=%h want all zero",
                  px_valid, busy, done, frame_count, in_rd_en, hold_rd_en, base_rd_en, obs);
      end
      @(negedge clock);
      reset = 1'b1; fifo_clr = 1'b0;
      tick(1, 0, 1, 0);
      tick(1, 0, 0, 0);
      vectors++;
      if ({busy, in_rd_en, hold_rd_en, base_rd_en, px_valid} !== 5'b0) begin
         errors++;
         $display("FAIL idle_no_pop: got busy=%b rd=%b%b%b valid=%b want 0 0000",
                  busy, in_rd_en, hold_rd_en, base_rd_en, px_valid);
      end
   endtask

   task automatic test_single_frame;
      int n, dn, last_pop, done_at, first_v, last_v;
      do_reset();
      wp = 8;
      n = 0; dn = 0; last_pop = -1; done_at = -1; first_v = -1; last_v = -1;
      tick(1, 1, 0, 0);
      for (int c = 0; c < 20; c++) begin
         tick(1, 0, 0, 0);
         if (in_rd_en) last_pop = c;
         if (done) begin dn++; done_at = c; end
         if (px_valid) begin
            if (first_v < 0) first_v = c;
            last_v = c;
         end
         if (px_valid && px_ready) begin
            vectors++;
            if (obs !== exp_beat(n, n)) begin
               errors++;
               $display("FAIL single_beat%0d: got %h want %h", n, obs, exp_beat(n, n));
            end
            n++;
         end
      end
      vectors++;
      if (n !== 8) begin errors++; $display("FAIL single_count: got %0d beats want 8", n); end
      vectors++;
      if (last_v - first_v !== 7) begin
         errors++; $display("FAIL single_contig: got span %0d want 7", last_v - first_v);
      end
      vectors++;
      if (dn !== 1 || done_at - last_pop !== 2) begin
         errors++; $display("FAIL single_done: got %0d pulses at +%0d want 1 at +2", dn, done_at - last_pop);
      end
      vectors++;
      if ({busy, frame_count} !== {1'b0, 2'd1}) begin
         errors++; $display("FAIL single_end: got busy=%b fc=%0d want busy=0 fc=1", busy, frame_count);
      end
   endtask

   task automatic test_stall;
      int    n, dn;
      beat_t held;
      logic  stalled;
      do_reset();
      wp = 8;
      n = 0; dn = 0; stalled = 1'b0; held = '0;
      tick(0, 1, 0, 0);
      for (int c = 0; c < 60; c++) begin
         tick((c % 4 == 0) || (c % 4 == 3), 0, 0, 0);
         vectors++;
         if ({in_rd_en, hold_rd_en} !== {base_rd_en, base_rd_en}) begin
            errors++; $display("FAIL stall_lockstep: got rd=%b%b%b want all equal", in_rd_en, hold_rd_en, base_rd_en);
         end
         if (px_valid && !px_ready) begin
            vectors++;
            if (in_rd_en !== 1'b0) begin errors++; $display("FAIL stall_pop: got rd_en=1 want 0"); end
         end
         if (stalled) begin
            vectors++;
            if ({px_valid, obs} !== {1'b1, held}) begin
               errors++; $display("FAIL stall_hold: got %b %h want 1 %h", px_valid, obs, held);
            end
         end
         stalled = px_valid && !px_ready;
         held    = obs;
         if (done) dn++;
         if (px_valid && px_ready) begin
            vectors++;
            if (obs !== exp_beat(n, n)) begin
               errors++; $display("FAIL stall_beat%0d: got %h want %h", n, obs, exp_beat(n, n));
            end
            n++;
         end
      end
      vectors++;
      if ({n, dn, frame_count} !== {32'd8, 32'd1, 2'd1}) begin
         errors++; $display("FAIL stall_end: got beats=%0d done=%0d fc=%0d want 8 1 1", n, dn, frame_count);
      end
   endtask

   task automatic test_base_gap;
      int   n, dn;
      logic gap;
      do_reset();
      wp = 8;
      n = 0; dn = 0;
      tick(1, 1, 0, 0);
      for (int c = 0; c < 30; c++) begin
         gap = (c >= 4) && (c < 9);
         tick(1, 0, 0, gap);
         if (gap) begin
            vectors++;
            if ({in_rd_en, hold_rd_en, base_rd_en} !== 3'b000) begin
               errors++; $display("FAIL gap_pop c%0d: got rd=%b%b%b want 000", c, in_rd_en, hold_rd_en, base_rd_en);
            end
         end
         vectors++;
         if (rp_in !== rp_base || rp_hold !== rp_base) begin
            errors++; $display("FAIL gap_occupancy c%0d: got pops %0d/%0d/%0d want equal", c, rp_in, rp_hold, rp_base);
         end
         if (done) dn++;
         if (px_valid && px_ready) begin
            vectors++;
            if (obs !== exp_beat(n, n)) begin
               errors++; $display("FAIL gap_beat%0d: got %h want %h", n, obs, exp_beat(n, n));
            end
            n++;
         end
      end
      vectors++;
      if ({n, dn, frame_count} !== {32'd8, 32'd1, 2'd1}) begin
         errors++; $display("FAIL gap_end: got beats=%0d done=%0d fc=%0d want 8 1 1", n, dn, frame_count);
      end
   endtask

   task automatic test_abort;
      int n, m, dn;
      do_reset();
      wp = 16;
      n = 0; m = 0; dn = 0;
      tick(1, 1, 0, 0);
      for (int c = 0; c < 4; c++) begin
         tick(1, 0, c == 3, 0);
         if (c == 3) begin
            vectors++;
            if ({in_rd_en, hold_rd_en, base_rd_en} !== 3'b000) begin
               errors++; $display("FAIL abort_gate: got rd=%b%b%b want 000", in_rd_en, hold_rd_en, base_rd_en);
            end
         end
         if (px_valid && px_ready) begin
            vectors++;
            if (obs !== exp_beat(n, n)) begin
               errors++; $display("FAIL abort_beat%0d: got %h want %h", n, obs, exp_beat(n, n));
            end
            n++;
         end
      end
      tick(1, 0, 0, 0);
      vectors++;
      if ({busy, px_valid} !== 2'b00) begin
         errors++; $display("FAIL abort_idle: got busy=%b valid=%b want 0 0", busy, px_valid);
      end
      for (int c = 0; c < 4; c++) begin
         tick(1, 0, 0, 0);
         if (done) dn++;
      end
      vectors++;
      if ({dn, frame_count, rp_in} !== {32'd0, 2'd0, 32'd3}) begin
         errors++; $display("FAIL abort_nodone: got done=%0d fc=%0d pops=%0d want 0 0 3", dn, frame_count, rp_in);
      end
      tick(1, 1, 1, 0);
      tick(1, 0, 0, 0);
      vectors++;
      if ({busy, in_rd_en} !== 2'b00) begin
         errors++; $display("FAIL abort_start_same: got busy=%b rd=%b want 0 0", busy, in_rd_en);
      end
      tick(1, 1, 0, 0);
      for (int c = 0; c < 20; c++) begin
         tick(1, 0, 0, 0);
         if (done) dn++;
         if (px_valid && px_ready) begin
            vectors++;
            if (obs !== exp_beat(3 + m, m)) begin
               errors++; $display("FAIL restart_beat%0d: got %h want %h", m, obs, exp_beat(3 + m, m));
            end
            m++;
         end
      end
      vectors++;
      if ({m, dn, frame_count} !== {32'd8, 32'd1, 2'd1}) begin
         errors++; $display("FAIL restart_end: got beats=%0d done=%0d fc=%0d want 8 1 1", m, dn, frame_count);
      end
   endtask

   task automatic test_continuous;
      int n, dn;
      do_reset();
      wp = 24;
      cfg_continuous = 1'b1;
      n = 0; dn = 0;
      tick(1, 1, 0, 0);
      for (int c = 0; c < 50; c++) begin
         tick(1, 0, 0, 0);
         if (done) dn++;
         if (px_valid && px_ready) begin
            vectors++;
            if (obs !== exp_beat(n, n)) begin
               errors++; $display("FAIL cont_beat%0d: got %h want %h", n, obs, exp_beat(n, n));
            end
            n++;
         end
      end
      vectors++;
      if ({n, dn, frame_count, busy} !== {32'd24, 32'd3, 2'd3, 1'b1}) begin
         errors++; $display("FAIL cont_end: got beats=%0d done=%0d fc=%0d busy=%b want 24 3 3 1",
                            n, dn, frame_count, busy);
      end
      cfg_continuous = 1'b0;
      tick(1, 0, 1, 0);
      tick(1, 0, 0, 0);
      vectors++;
      if ({busy, frame_count} !== {1'b0, 2'd3}) begin
         errors++; $display("FAIL cont_abort: got busy=%b fc=%0d want 0 3", busy, frame_count);
      end
   endtask

   task automatic test_wrap;
      int   n;
      logic got_done;
      logic [FCNT_W-1:0] want;
      do_reset();
      wp = 48;
      n = 0;
      for (int f = 0; f < 5; f++) begin
         got_done = 1'b0;
         tick(1, 1, 0, 0);
         for (int c = 0; c < 30 && !got_done; c++) begin
            tick(1, c == 3, 0, 0);
            if (done) got_done = 1'b1;
            if (px_valid && px_ready) begin
               vectors++;
               if (obs !== exp_beat(n, n)) begin
                  errors++; $display("FAIL wrap_beat%0d: got %h want %h", n, obs, exp_beat(n, n));
               end
               n++;
            end
         end
         vectors++;
         if (!got_done) begin errors++; $display("FAIL wrap_timeout f%0d: got no done want done", f); end
         tick(1, 0, 0, 0);
         want = FCNT_W'(f + 1);
         vectors++;
         if ({busy, frame_count} !== {1'b0, want}) begin
            errors++; $display("FAIL wrap_count f%0d: got busy=%b fc=%0d want 0 %0d", f, busy, frame_count, want);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem_in[i]   = 24'h110000 + 24'(i);
         mem_hold[i] = 24'h220000 + 24'(i);
         mem_base[i] = 24'h330000 + 24'(i);
      end
      test_reset();
      test_single_frame();
      test_stall();
      test_base_gap();
      test_abort();
      test_continuous();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
